// File: rtl/traffic_ctrl_param.sv
// traffic_ctrl_param: two-road (highway HL / farm road FL) lamp controller with
// all-red clearance, minimum HL green, sticky FL/pedestrian requests, optional walk.
// Latency: registered outputs; lamps/phase change on the same edge as the state.
// Flow: no backpressure; c and ped_req are sampled every cycle and latched as requests.
// Optional feature macro: TRAFFIC_PED_EN (pedestrian walk phase; walk tied 0 otherwise).
// Ports: clk, rst (async active-low), c (FL sensor), ped_req (walk button pulse),
//        hl_green/hl_yellow/hl_red, fl_green/fl_yellow/fl_red, walk, phase[2:0].
module traffic_ctrl_param #(
   parameter int TW       = 8,
   parameter int T_HL_MIN = 16,
   parameter int T_YEL    = 3,
   parameter int T_CLR    = 2,
   parameter int T_FL_GRN = 8,
   parameter int T_WALK   = 6
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       c,
   input  logic       ped_req,
   output logic       hl_green,
   output logic       hl_yellow,
   output logic       hl_red,
   output logic       fl_green,
   output logic       fl_yellow,
   output logic       fl_red,
   output logic       walk,
   output logic [2:0] phase
);

   localparam logic [2:0] HL_GRN = 3'd0;
   localparam logic [2:0] HL_YEL = 3'd1;
   localparam logic [2:0] CLR_A  = 3'd2;
   localparam logic [2:0] FL_GRN = 3'd3;
   localparam logic [2:0] FL_YEL = 3'd4;
   localparam logic [2:0] CLR_B  = 3'd5;
   localparam logic [2:0] WALK   = 3'd6;

   localparam logic [TW-1:0] HL_MIN_M1 = TW'(T_HL_MIN - 1);
   localparam logic [TW-1:0] YEL_M1    = TW'(T_YEL - 1);
   localparam logic [TW-1:0] CLR_M1    = TW'(T_CLR - 1);
   localparam logic [TW-1:0] FL_GRN_M1 = TW'(T_FL_GRN - 1);

   logic [2:0]    state, nxt;
   logic [TW-1:0] tmr;
   logic          fl_pend;
   logic          ped_pend;
   logic          walk_done;

`ifdef TRAFFIC_PED_EN
   localparam bit PED_ON = 1'b1;
   localparam logic [TW-1:0] WALK_M1 = TW'(T_WALK - 1);

   assign walk_done = (tmr == WALK_M1);

   // Cleared on the WALK entry edge; a button press on that edge is absorbed.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst)
         ped_pend <= 1'b0;
      else if (nxt == WALK && state != WALK)
         ped_pend <= 1'b0;
      else if (ped_req && state != WALK)
         ped_pend <= 1'b1;
   end
`else
   localparam bit PED_ON = 1'b0;
   logic unused_ped;

   assign ped_pend   = 1'b0;
   assign walk_done  = 1'b1;
   assign unused_ped = ^{ped_req, TW'(T_WALK)};
`endif

   // State register
   always_ff @(posedge clk or negedge rst) begin
      if (!rst)
         state <= HL_GRN;
      else
         state <= nxt;
   end

   // Next-state logic; unlisted encodings (7, and 6 without the walk phase) recover to HL_GRN
   always_comb begin
      nxt = state;
      case (state)
         HL_GRN: if (tmr >= HL_MIN_M1 && (fl_pend || c || ped_pend)) nxt = HL_YEL;
         HL_YEL: if (tmr == YEL_M1) nxt = CLR_A;
         // WALK is only chosen when the sole outstanding request was a pedestrian one
         CLR_A:  if (tmr == CLR_M1) nxt = (fl_pend || c || !PED_ON) ? FL_GRN : WALK;
         FL_GRN: if (tmr == FL_GRN_M1) nxt = FL_YEL;
         FL_YEL: if (tmr == YEL_M1) nxt = CLR_B;
         CLR_B:  if (tmr == CLR_M1) nxt = ped_pend ? WALK : HL_GRN;
         WALK:   nxt = !PED_ON ? HL_GRN : (walk_done ? HL_GRN : WALK);
         default: nxt = HL_GRN;
      endcase
   end

   // Phase timer; holds at all-ones in HL_GRN so an idle highway never wraps
   always_ff @(posedge clk or negedge rst) begin
      if (!rst)
         tmr <= '0;
      else if (nxt != state)
         tmr <= '0;
      else if (!(state == HL_GRN && (&tmr)))
         tmr <= tmr + 1'b1;
   end

   // FL request; cleared on FL_GRN entry even if c is high on that same edge
   always_ff @(posedge clk or negedge rst) begin
      if (!rst)
         fl_pend <= 1'b0;
      else if (nxt == FL_GRN && state != FL_GRN)
         fl_pend <= 1'b0;
      else if (c && state != FL_GRN)
         fl_pend <= 1'b1;
   end

   // Output decode from the next state, registered so lamps move with the state
   logic [6:0] lamp_d;
   always_comb begin
      lamp_d = 7'b001_001_0;
      case (nxt)
         HL_GRN: lamp_d = 7'b100_001_0;
         HL_YEL: lamp_d = 7'b010_001_0;
         FL_GRN: lamp_d = 7'b001_100_0;
         FL_YEL: lamp_d = 7'b001_010_0;
         WALK:   lamp_d = {6'b001_001, PED_ON};
         default: lamp_d = 7'b001_001_0;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         {hl_green, hl_yellow, hl_red, fl_green, fl_yellow, fl_red, walk} <= 7'b100_001_0;
         phase <= HL_GRN;
      end else begin
         {hl_green, hl_yellow, hl_red, fl_green, fl_yellow, fl_red, walk} <= lamp_d;
         phase <= nxt;
      end
   end

endmodule
